// File: rtl/pcpi_bridge_pkg.sv
// Shared constants and state encoding for the nibble-serial PCPI bridge
// (outbound result transmitter and inbound instruction receiver).
package pcpi_bridge_pkg;

  localparam int PCPI_NIB_W   = 4;
  localparam int PCPI_DATA_W  = 32;
  localparam int PCPI_NUM_NIB = PCPI_DATA_W / PCPI_NIB_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_SEND    = 2'd2,
    ST_RELEASE = 2'd3
  } pcpi_nib_state_e;

  function automatic int num_nib(input int data_w, input int nib_w);
    return data_w / nib_w;
  endfunction

  // Counter width that stays legal even for a single-nibble word.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcpi_sync_ff.sv
// Multi-flop single-bit synchroniser with synchronous active-low reset to 0.
module pcpi_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pcpi_result_nibble_tx.sv
// Nibble-serial return path: captures a PCPI result word and sends it to the
// host LSB nibble first, one four-phase valid/ack handshake per nibble.
module pcpi_result_nibble_tx
  import pcpi_bridge_pkg::*;
#(
  parameter int DATA_W      = PCPI_DATA_W,
  parameter int NIB_W       = PCPI_NIB_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              host_ack,
  output logic [NIB_W-1:0]  nib_out,
  output logic              nib_valid,
  output logic              nib_last,
  output logic              busy,
  output logic              done
);

  localparam int NUM_NIB = num_nib(DATA_W, NIB_W);
  localparam int CNT_W   = cnt_w(NUM_NIB);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NIB - 1);

  logic ack_s;

  pcpi_sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (host_ack),
    .q     (ack_s)
  );

  pcpi_nib_state_e   state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [NIB_W-1:0]  nib_out_q, nib_out_d;
  logic              nib_valid_q, nib_valid_d;
  logic              nib_last_q, nib_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_ready_q, load_ready_d;

  // Outputs are computed for the state being entered, so every port is a flop.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    count_d      = count_q;
    nib_out_d    = nib_out_q;
    nib_valid_d  = nib_valid_q;
    nib_last_d   = nib_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    load_ready_d = load_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          shreg_d      = load_data;
          count_d      = '0;
          busy_d       = 1'b1;
          load_ready_d = 1'b0;
          // A host ack still high from an earlier transfer must drop first.
          if (ack_s) begin
            state_d = ST_ARM;
          end else begin
            state_d     = ST_SEND;
            nib_valid_d = 1'b1;
            nib_out_d   = load_data[NIB_W-1:0];
            nib_last_d  = (LAST_IDX == '0);
          end
        end
      end
      ST_ARM: begin
        if (!ack_s) begin
          state_d     = ST_SEND;
          nib_valid_d = 1'b1;
          nib_out_d   = shreg_q[NIB_W-1:0];
          nib_last_d  = (count_q == LAST_IDX);
        end
      end
      ST_SEND: begin
        if (ack_s) begin
          state_d     = ST_RELEASE;
          nib_valid_d = 1'b0;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          if (count_q == LAST_IDX) begin
            state_d      = ST_IDLE;
            done_d       = 1'b1;
            nib_out_d    = '0;
            nib_last_d   = 1'b0;
            busy_d       = 1'b0;
            load_ready_d = 1'b1;
          end else begin
            shreg_d     = shreg_q >> NIB_W;
            count_d     = count_q + 1'b1;
            state_d     = ST_SEND;
            nib_valid_d = 1'b1;
            nib_out_d   = shreg_d[NIB_W-1:0];
            nib_last_d  = (count_d == LAST_IDX);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      count_q      <= '0;
      nib_out_q    <= '0;
      nib_valid_q  <= 1'b0;
      nib_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      count_q      <= count_d;
      nib_out_q    <= nib_out_d;
      nib_valid_q  <= nib_valid_d;
      nib_last_q   <= nib_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign load_ready = load_ready_q;
  assign nib_out    = nib_out_q;
  assign nib_valid  = nib_valid_q;
  assign nib_last   = nib_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
